// File: rtl/tds_readout_pkg.sv
// Shared types and constants for the TDS trigger-match readout.
// TDS_TRIG_TAG_EN adds the latched trigger index to the tag field.
package tds_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_HDR,
    ST_TAG,
    ST_PAYLOAD,
    ST_POP,
    ST_TRAILER
  } rd_state_t;

  localparam int HDR_LEN = 14;
  localparam int TRL_LEN = 2;

`ifdef TDS_TRIG_TAG_EN
  localparam int TAG_LEN = 2;
`else
  localparam int TAG_LEN = 1;
`endif

  // A zero threshold would never close a frame, so it acts as one word.
  function automatic logic [15:0] eff_th(input logic [11:0] th);
    return (th == 12'd0) ? 16'd1 : {4'd0, th};
  endfunction

endpackage

// File: rtl/tds_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after last winner.
// Pointer moves to the granted channel only when the grant is accepted.
module tds_rr_arbiter
  import tds_readout_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr;
  logic          found;

  // Scan from ptr+1 upward with wrap, first requester wins.
  always_comb begin
    int j;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

  // Remember the last accepted winner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= IW'(N - 1);
    end else if (accept && found) begin
      ptr <= gnt_idx;
    end
  end

endmodule

// File: rtl/tds_trigger_match_readout.sv
// Packs TDS channel FIFO words into Ethernet frames on a byte AXI-stream.
// Build option: TDS_TRIG_TAG_EN appends trigger_index after the channel id.
module tds_trigger_match_readout
  import tds_readout_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          DATA_W   = 120,
  parameter int          CNT_W    = 10,
  parameter logic [15:0] ETH_TYPE = 16'h88B5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [47:0]              d_mac_add,
  input  logic [47:0]              s_mac_add,
  input  logic [11:0]              counter_th,
  input  logic [15:0]              idle_counter_number_th,
  input  logic [7:0]               trigger_index,
  input  logic [N_CH-1:0]          channel_linked,
  input  logic [N_CH*DATA_W-1:0]   channel_data,
  input  logic [N_CH*CNT_W-1:0]    channel_data_counter,
  input  logic [N_CH-1:0]          channel_fifo_empty,
  output logic [N_CH-1:0]          channel_data_read,
  output logic [7:0]               tx_axis_fifo_tdata,
  output logic                     tx_axis_fifo_tvalid,
  input  logic                     tx_axis_fifo_tready,
  output logic                     tx_axis_fifo_tlast
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  rd_state_t          st;
  logic [7:0]         idx;
  logic [IDX_W-1:0]   win_idx;
  logic [N_CH-1:0]    win_oh;
  logic [15:0]        wcnt;
  logic [15:0]        idle_cnt;

  logic [15:0]        th_eff;
  logic               flush_exp;
  logic [N_CH-1:0]    cand;
  logic [N_CH-1:0]    at_th;
  logic [N_CH-1:0]    elig;
  logic [N_CH-1:0]    gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               sel_acc;
  logic               hs;

  logic [HDR_LEN*8-1:0] hdr_bits;
  logic [DATA_W-1:0]    head;
  logic [7:0]           hdr_nxt;
  logic [7:0]           pay_nxt;
  logic [7:0]           pay_first;
  logic [7:0]           id_byte;
  logic [7:0]           tag_b1;

  assign th_eff    = eff_th(counter_th);
  assign flush_exp = (idle_counter_number_th != 16'd0) &&
                     (idle_cnt >= idle_counter_number_th);
  assign hs        = tx_axis_fifo_tvalid && tx_axis_fifo_tready;
  assign sel_acc   = (st == ST_SELECT);
  assign hdr_bits  = {d_mac_add, s_mac_add, ETH_TYPE};
  assign head      = channel_data[int'(win_idx)*DATA_W +: DATA_W];
  assign pay_first = head[DATA_W-1 -: 8];
  assign id_byte   = 8'(win_idx);

  // Per-channel readiness: linked with data, and full enough or flushed.
  always_comb begin
    cand  = '0;
    at_th = '0;
    elig  = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand[i]  = channel_linked[i] && !channel_fifo_empty[i];
      at_th[i] = cand[i] &&
        (32'(channel_data_counter[i*CNT_W +: CNT_W]) >= 32'(th_eff));
      elig[i]  = cand[i] && (at_th[i] || flush_exp);
    end
  end

  // Next byte of the header / payload word for the current byte index.
  always_comb begin
    hdr_nxt = '0;
    pay_nxt = '0;
    if (int'(idx) < HDR_LEN - 1)
      hdr_nxt = hdr_bits[(HDR_LEN-2-int'(idx))*8 +: 8];
    if (int'(idx) < NB - 1)
      pay_nxt = head[(NB-2-int'(idx))*8 +: 8];
  end

  tds_rr_arbiter #(
    .N  (N_CH),
    .IW (IDX_W)
  ) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (elig),
    .accept  (sel_acc),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

`ifdef TDS_TRIG_TAG_EN
  logic [7:0] trig_q;

  // Trigger tag is frozen for the whole frame at selection time.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      trig_q <= '0;
    else if (st == ST_SELECT)
      trig_q <= trigger_index;
  end

  assign tag_b1 = trig_q;
`else
  logic unused_trig;
  assign unused_trig = ^trigger_index;
  assign tag_b1      = 8'h00;
`endif

  // Flush timer: runs while data waits below threshold, cleared per frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if (st == ST_SELECT) begin
      idle_cnt <= '0;
    end else if (st == ST_IDLE && |cand && !(|at_th) &&
                 idle_cnt < idle_counter_number_th) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // Frame sequencer with registered stream outputs and pop strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st                  <= ST_IDLE;
      idx                 <= '0;
      win_idx             <= '0;
      win_oh              <= '0;
      wcnt                <= '0;
      tx_axis_fifo_tdata  <= '0;
      tx_axis_fifo_tvalid <= 1'b0;
      tx_axis_fifo_tlast  <= 1'b0;
      channel_data_read   <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (|elig)
            st <= ST_SELECT;
        end
        ST_SELECT: begin
          if (|elig) begin
            win_idx             <= gnt_idx;
            win_oh              <= gnt;
            wcnt                <= '0;
            idx                 <= '0;
            tx_axis_fifo_tdata  <= hdr_bits[HDR_LEN*8-1 -: 8];
            tx_axis_fifo_tvalid <= 1'b1;
            tx_axis_fifo_tlast  <= 1'b0;
            st                  <= ST_HDR;
          end else begin
            st <= ST_IDLE;
          end
        end
        ST_HDR: begin
          if (hs) begin
            if (int'(idx) == HDR_LEN - 1) begin
              idx                <= '0;
              tx_axis_fifo_tdata <= id_byte;
              st                 <= ST_TAG;
            end else begin
              idx                <= idx + 8'd1;
              tx_axis_fifo_tdata <= hdr_nxt;
            end
          end
        end
        ST_TAG: begin
          if (hs) begin
            if (int'(idx) < TAG_LEN - 1) begin
              idx                <= idx + 8'd1;
              tx_axis_fifo_tdata <= tag_b1;
            end else begin
              idx                <= '0;
              tx_axis_fifo_tdata <= pay_first;
              st                 <= ST_PAYLOAD;
            end
          end
        end
        ST_PAYLOAD: begin
          if (hs) begin
            if (int'(idx) == NB - 1) begin
              idx                 <= '0;
              tx_axis_fifo_tvalid <= 1'b0;
              channel_data_read   <= win_oh;
              wcnt                <= wcnt + 16'd1;
              st                  <= ST_POP;
            end else begin
              idx                <= idx + 8'd1;
              tx_axis_fifo_tdata <= pay_nxt;
            end
          end
        end
        ST_POP: begin
          // First cycle carries the strobe; second sees the post-pop FIFO.
          if (|channel_data_read) begin
            channel_data_read <= '0;
          end else if (wcnt < th_eff &&
                       !channel_fifo_empty[win_idx]) begin
            idx                 <= '0;
            tx_axis_fifo_tdata  <= pay_first;
            tx_axis_fifo_tvalid <= 1'b1;
            st                  <= ST_PAYLOAD;
          end else begin
            idx                 <= '0;
            tx_axis_fifo_tdata  <= wcnt[15:8];
            tx_axis_fifo_tvalid <= 1'b1;
            st                  <= ST_TRAILER;
          end
        end
        ST_TRAILER: begin
          if (hs) begin
            if (int'(idx) == TRL_LEN - 1) begin
              idx                 <= '0;
              tx_axis_fifo_tvalid <= 1'b0;
              tx_axis_fifo_tlast  <= 1'b0;
              st                  <= ST_IDLE;
            end else begin
              idx                <= idx + 8'd1;
              tx_axis_fifo_tdata <= wcnt[7:0];
              tx_axis_fifo_tlast <= 1'b1;
            end
          end
        end
        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tds_trigger_match_readout.sv
// Scoreboard bench for tds_trigger_match_readout with FIFO models.
// Directed frames, flush timing, stalls, mid-frame reset, optional tag.
module tb_tds_trigger_match_readout;

  localparam int N_CH   = 4;
  localparam int DATA_W = 120;
  localparam int CNT_W  = 10;
  localparam int NB     = DATA_W / 8;
  localparam int DEPTH  = 64;
`ifdef TDS_TRIG_TAG_EN
  localparam int TAG_EXTRA = 1;
`else
  localparam int TAG_EXTRA = 0;
`endif
  localparam int FLEN = 14 + 1 + TAG_EXTRA + 2 * NB + 2;

  localparam logic [47:0] DMAC = 48'h0102_0304_0506;
  localparam logic [47:0] SMAC = 48'hA1A2_A3A4_A5A6;

  logic                    clk;
  logic                    reset_n;
  logic [11:0]             counter_th;
  logic [15:0]             idle_th;
  logic [7:0]              trigger_index;
  logic [N_CH-1:0]         linked;
  logic [N_CH*DATA_W-1:0]  ch_data;
  logic [N_CH*CNT_W-1:0]   ch_cnt;
  logic [N_CH-1:0]         ch_empty;
  logic [N_CH-1:0]         ch_read;
  logic [7:0]              tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  logic [DATA_W-1:0] mem [N_CH][DEPTH];
  int wr [N_CH];
  int rd [N_CH];

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } xb_t;
  xb_t exp_q[$];

  int n_pass;
  int n_total;
  int bytes_seen;
  int frame_len;
  int last_frame_len;
  int pops [N_CH];
  bit stall;
  int cyc;

  tds_trigger_match_readout #(
    .N_CH     (N_CH),
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .ETH_TYPE (16'h88B5)
  ) dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .d_mac_add              (DMAC),
    .s_mac_add              (SMAC),
    .counter_th             (counter_th),
    .idle_counter_number_th (idle_th),
    .trigger_index          (trigger_index),
    .channel_linked         (linked),
    .channel_data           (ch_data),
    .channel_data_counter   (ch_cnt),
    .channel_fifo_empty     (ch_empty),
    .channel_data_read      (ch_read),
    .tx_axis_fifo_tdata     (tdata),
    .tx_axis_fifo_tvalid    (tvalid),
    .tx_axis_fifo_tready    (tready),
    .tx_axis_fifo_tlast     (tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FWFT FIFO heads and status.
  always_comb begin
    ch_data  = '0;
    ch_cnt   = '0;
    ch_empty = '0;
    for (int i = 0; i < N_CH; i++) begin
      ch_data[i*DATA_W +: DATA_W] = mem[i][rd[i] % DEPTH];
      ch_cnt[i*CNT_W +: CNT_W]    = CNT_W'(wr[i] - rd[i]);
      ch_empty[i]                 = (wr[i] == rd[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_CH; i++)
      if (ch_read[i]) rd[i] <= rd[i] + 1;
  end

  initial begin
    tready = 1'b1;
    cyc    = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      tready = stall ? (cyc % 3 == 0) : 1'b1;
    end
  end

  task automatic chk(input string nm, input bit ok,
                     input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endtask

  // Monitor: compare handshaken bytes, stall stability, pop strobes.
  initial begin
    bit         prev_stall;
    logic [8:0] prev_v;
    xb_t        e;
    prev_stall = 1'b0;
    prev_v     = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_stall = 1'b0;
        frame_len  = 0;
      end else begin
        if (prev_stall)
          chk("stall_hold", tvalid && {tlast, tdata} == prev_v,
              {22'd0, tvalid, tlast, tdata}, {23'd1, prev_v});
        if (|ch_read) begin
          chk("pop_onehot", $countones(ch_read) == 1,
              32'(ch_read), 32'd1);
          for (int i = 0; i < N_CH; i++)
            if (ch_read[i]) pops[i]++;
        end
        if (tvalid && tready) begin
          chk("extra_byte", exp_q.size() != 0, {23'd0, tlast, tdata}, 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("byte", {tlast, tdata} == e,
                {23'd0, tlast, tdata}, {23'd0, e});
          end
          bytes_seen++;
          frame_len++;
          if (tlast) begin
            last_frame_len = frame_len;
            frame_len      = 0;
          end
        end
        prev_stall = tvalid && !tready;
        prev_v     = {tlast, tdata};
      end
    end
  end

  task automatic load(input int ch, input int n);
    logic [DATA_W-1:0] w;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < NB; k++)
        w[k*8 +: 8] = 8'(ch * 40 + wr[ch] * 16 + k + 1);
      mem[ch][wr[ch] % DEPTH] = w;
      wr[ch]++;
    end
  endtask

  task automatic fifo_clear(input int ch);
    wr[ch] = rd[ch];
  endtask

  task automatic push_frame(input int ch, input int off, input int nw);
    logic [111:0]      h;
    logic [DATA_W-1:0] w;
    logic [15:0]       c;
    h = {DMAC, SMAC, 16'h88B5};
    c = 16'(nw);
    for (int k = 0; k < 14; k++)
      exp_q.push_back({1'b0, h[(13-k)*8 +: 8]});
    exp_q.push_back({1'b0, 8'(ch)});
`ifdef TDS_TRIG_TAG_EN
    exp_q.push_back({1'b0, 8'hA5});
`endif
    for (int j = 0; j < nw; j++) begin
      w = mem[ch][(rd[ch] + off + j) % DEPTH];
      for (int k = 0; k < NB; k++)
        exp_q.push_back({1'b0, w[(NB-1-k)*8 +: 8]});
    end
    exp_q.push_back({1'b0, c[15:8]});
    exp_q.push_back({1'b1, c[7:0]});
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || frame_len != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(nm, exp_q.size() == 0, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int b0;
    int p0;
    int n;
    n_pass         = 0;
    n_total        = 0;
    bytes_seen     = 0;
    frame_len      = 0;
    last_frame_len = 0;
    stall          = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      wr[i]   = 0;
      pops[i] = 0;
    end
    reset_n       = 1'b0;
    counter_th    = 12'd2;
    idle_th       = 16'd0;
    trigger_index = 8'hA5;
    linked        = '1;

    repeat (2) @(negedge clk);
    chk("rst_tdata", tdata == 8'h00, 32'(tdata), 0);
    chk("rst_tvalid", tvalid == 1'b0, 32'(tvalid), 0);
    chk("rst_tlast", tlast == 1'b0, 32'(tlast), 0);
    chk("rst_read", ch_read == '0, 32'(ch_read), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame: ch1 holds 3 words, threshold 2.
    p0 = pops[1];
    load(1, 3);
    push_frame(1, 0, 2);
    drain("s1_drain", 400);
    chk("s1_len", last_frame_len == FLEN, last_frame_len, FLEN);
    chk("s1_pops", pops[1] - p0 == 2, pops[1] - p0, 2);
    fifo_clear(1);

    // Round robin between ch0 and ch2.
    do_reset();
    load(0, 4);
    load(2, 2);
    push_frame(0, 0, 2);
    push_frame(2, 0, 2);
    push_frame(0, 2, 2);
    drain("s2_drain", 800);

    // Flush timeout on a single word below threshold.
    counter_th = 12'd100;
    idle_th    = 16'd50;
    b0 = bytes_seen;
    load(3, 1);
    push_frame(3, 0, 1);
    n = 0;
    while (bytes_seen == b0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("s3_latency", n >= 48 && n <= 58, n, 53);
    drain("s3_drain", 400);

    // Flush disabled: the word must stay put.
    idle_th = 16'd0;
    b0 = bytes_seen;
    load(3, 1);
    repeat (300) @(posedge clk);
    #1;
    chk("s3_noflush", bytes_seen == b0, bytes_seen - b0, 0);
    fifo_clear(3);
    counter_th = 12'd2;

    // Backpressure: same frame with tready at 1/3 duty.
    stall = 1'b1;
    p0 = pops[1];
    load(1, 3);
    push_frame(1, 0, 2);
    drain("s4_drain", 1200);
    chk("s4_len", last_frame_len == FLEN, last_frame_len, FLEN);
    chk("s4_pops", pops[1] - p0 == 2, pops[1] - p0, 2);
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    fifo_clear(1);

    // Reset in the middle of a frame, then a clean frame.
    b0 = bytes_seen;
    load(1, 3);
    push_frame(1, 0, 2);
    n = 0;
    while (bytes_seen - b0 < 20 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("s5_reach20", bytes_seen - b0 >= 20, bytes_seen - b0, 20);
    #1;
    reset_n = 1'b0;
    p0 = pops[1];
    @(negedge clk);
    chk("s5_tvalid", tvalid == 1'b0, 32'(tvalid), 0);
    chk("s5_tlast", tlast == 1'b0, 32'(tlast), 0);
    chk("s5_read", ch_read == '0, 32'(ch_read), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("s5_nopop", rd[1] == wr[1] - 3, wr[1] - rd[1], 3);
    push_frame(1, 0, 2);
    reset_n = 1'b1;
    drain("s5_drain", 400);
    chk("s5_len", last_frame_len == FLEN, last_frame_len, FLEN);
    chk("s5_pops", pops[1] - p0 == 2, pops[1] - p0, 2);
    fifo_clear(1);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
